// File: rtl/spi_flash_reader_if.sv
// Instruction-bus interface between the CPU fetch unit and the SPI flash reader.
//   wb_adr  : byte address of the requested word (master -> slave)
//   wb_cyc  : request strobe, held until wb_ack (master -> slave)
//   wb_rdt  : little-endian read data, valid while wb_ack is high (slave -> master)
//   wb_ack  : one-cycle completion pulse (slave -> master)
interface spi_flash_reader_if;
    logic [23:0] wb_adr;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    modport master (output wb_adr, output wb_cyc, input wb_rdt, input wb_ack);
    modport slave  (input wb_adr, input wb_cyc, output wb_rdt, output wb_ack);
endinterface

// File: rtl/spi_flash_reader.sv
// Instruction-fetch bridge from the CPU instruction bus to an SPI NOR flash.
// Every request becomes one READ transaction: 8-bit opcode, 24-bit word-aligned
// address, then 32 data bits. The word is returned little-endian (first flash
// byte in bits [7:0]) together with a single-cycle ack.
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active high
//   wb          instruction bus (slave side): wb_adr, wb_cyc in; wb_rdt, wb_ack out
//   o_spi_csb   flash chip select, active low
//   o_spi_sck   SPI clock, mode 0 (idles low), half period = CLK_DIV clocks
//   o_spi_mosi  serial data to the flash, MSB first
//   i_spi_miso  serial data from the flash
module spi_flash_reader #(
    parameter int          CLK_DIV  = 1,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spi_flash_reader_if.slave    wb,
    output logic                 o_spi_csb,
    output logic                 o_spi_sck,
    output logic                 o_spi_mosi,
    input  logic                 i_spi_miso
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK,
        ST_GAP
    } state_t;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_bit_cnt;
    logic [63:0]      r_tx;
    logic [30:0]      r_rx;
    logic [31:0]      r_rdt;
    logic             r_csb;
    logic             r_sck;
    logic             r_ack;

    logic             w_start;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_last;
    logic [31:0]      w_rx_next;
    logic [63:0]      w_tx_load;
    logic             w_unused_adr_lsb;

    // The two address LSBs are word-offset bits that never reach the wire.
    assign w_unused_adr_lsb = &{1'b0, wb.wb_adr[1:0]};

    // Data bits of the frame are clocked out as zero.
    assign w_tx_load = {READ_CMD, wb.wb_adr[23:2], 2'b00, 32'h0000_0000};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from values sampled before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and SCK edge decode.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_tick       = (r_div == DIV_LAST);
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_last       = 1'b0;
        w_rx_next    = {r_rx, i_spi_miso};

        case (r_state)
            ST_IDLE: begin
                if (wb.wb_cyc) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A half phase ends on the tick; its kind depends on the current SCK level.
                w_rise = w_tick && !r_sck;
                w_fall = w_tick &&  r_sck;
                w_last = w_fall && (r_bit_cnt == 6'd63);
                if (w_last) begin
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK:  w_state_next = ST_GAP;
            ST_GAP:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: divider, bit counter, shift registers and pin drivers.
    // NOTE: the read-data register is reset along with the control state because
    // its reset value is observable on the bus; it is a single word, not a memory.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rdt     <= '0;
            r_csb     <= 1'b1;
            r_sck     <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= 1'b0;

            if (w_start) begin
                // Divider restarts here so SCK timing never depends on history.
                r_tx      <= w_tx_load;
                r_rx      <= '0;
                r_div     <= '0;
                r_bit_cnt <= '0;
                r_csb     <= 1'b0;
                r_sck     <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);

                if (w_rise) begin
                    r_sck <= 1'b1;
                end

                if (w_fall) begin
                    r_sck <= 1'b0;
                    // MOSI advances on the same edge that samples MISO.
                    r_tx  <= {r_tx[62:0], 1'b0};
                    if (r_bit_cnt[5]) begin
                        r_rx <= w_rx_next[30:0];
                    end
                    if (w_last) begin
                        r_csb <= 1'b1;
                        r_ack <= 1'b1;
                        // First flash byte arrived first, so it sits in the top byte.
                        r_rdt <= {w_rx_next[7:0], w_rx_next[15:8],
                                  w_rx_next[23:16], w_rx_next[31:24]};
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
            end
        end
    end

    // After 64 shifts the TX register is all zero, so MOSI idles low in ACK/GAP/IDLE.
    assign o_spi_mosi = r_tx[63];
    assign o_spi_csb  = r_csb;
    assign o_spi_sck  = r_sck;
    assign wb.wb_ack  = r_ack;
    assign wb.wb_rdt  = r_rdt;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed testbench for spi_flash_reader: two instances (CLK_DIV=1 and 3),
// each attached to a behavioural SPI NOR flash (mode 0, READ command).
// Flash contents: bytes 0..3 = 11 22 33 44, every other byte i = i[7:0] ^ 8'h5A.
module tb_spi_flash_reader;

    logic clk;
    logic rst;
    logic sel;   // 0: CLK_DIV=1 instance, 1: CLK_DIV=3 instance

    spi_flash_reader_if bus1 ();
    spi_flash_reader_if bus3 ();

    logic csb1, sck1, mosi1, miso1;
    logic csb3, sck3, mosi3, miso3;

    logic [7:0] mem [0:511];

    int n_checks = 0;
    int n_errors = 0;

    spi_flash_reader #(.CLK_DIV(1), .READ_CMD(8'h03)) dut1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .wb         (bus1.slave),
        .o_spi_csb  (csb1),
        .o_spi_sck  (sck1),
        .o_spi_mosi (mosi1),
        .i_spi_miso (miso1)
    );

    spi_flash_reader #(.CLK_DIV(3), .READ_CMD(8'h03)) dut3 (
        .i_clk      (clk),
        .i_rst      (rst),
        .wb         (bus3.slave),
        .o_spi_csb  (csb3),
        .o_spi_sck  (sck3),
        .o_spi_mosi (mosi3),
        .i_spi_miso (miso3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural flash: captures opcode+address on rising SCK, drives data on falling SCK.
    for (genvar g = 0; g < 2; g++) begin : g_flash
        logic        f_csb, f_sck, f_mosi;
        logic        f_miso = 1'b0;
        int          f_cnt  = 0;
        logic [31:0] f_hdr  = '0;

        assign f_csb  = (g == 0) ? csb1  : csb3;
        assign f_sck  = (g == 0) ? sck1  : sck3;
        assign f_mosi = (g == 0) ? mosi1 : mosi3;

        always @(posedge f_sck or posedge f_csb) begin
            if (f_csb) begin
                f_cnt = 0;
            end else begin
                if (f_cnt < 32) f_hdr = {f_hdr[30:0], f_mosi};
                f_cnt = f_cnt + 1;
            end
        end

        always @(negedge f_sck) begin
            int j;
            int a;
            if (f_csb === 1'b0 && f_cnt >= 32 && f_cnt < 64) begin
                j      = f_cnt - 32;
                a      = (int'(f_hdr[23:0]) + j / 8) % 512;
                f_miso = mem[a][7 - (j % 8)];
            end
        end
    end

    assign miso1 = g_flash[0].f_miso;
    assign miso3 = g_flash[1].f_miso;

    wire        ack_m  = sel ? bus3.wb_ack : bus1.wb_ack;
    wire [31:0] rdt_m  = sel ? bus3.wb_rdt : bus1.wb_rdt;
    wire        csb_m  = sel ? csb3  : csb1;
    wire        sck_m  = sel ? sck3  : sck1;
    wire        mosi_m = sel ? mosi3 : mosi1;
    wire [31:0] hdr_m  = sel ? g_flash[1].f_hdr : g_flash[0].f_hdr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cyc(input logic v);
        if (sel) bus3.wb_cyc = v;
        else     bus1.wb_cyc = v;
    endtask

    task automatic set_adr(input logic [23:0] a);
        if (sel) bus3.wb_adr = a;
        else     bus1.wb_adr = a;
    endtask

    // Raise a request; returns just after the sampling edge E0.
    task automatic start(input logic [23:0] a);
        set_adr(a);
        set_cyc(1'b1);
        tick();
    endtask

    // Called just after E0. Follows the transfer to its ack and checks timing and data.
    task automatic wait_ack(input string tag, input int d, input logic [31:0] exp_hdr,
                            input logic [31:0] exp_rdt, input bit keep_cyc, input int drop_at);
        int   n, low, rise1, rise2;
        bit   seen;
        logic prev_sck;
        n = 0; low = 0; rise1 = -1; rise2 = -1; seen = 0; prev_sck = 1'b0;
        check({tag, ":csb_at_e0"}, {31'd0, csb_m}, 32'd0);
        while (n < 2000 && !seen) begin
            if (csb_m === 1'b0) low++;
            if (sck_m === 1'b1 && prev_sck === 1'b0) begin
                if (rise1 < 0)      rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
            prev_sck = sck_m;
            if (n == drop_at) set_cyc(1'b0);
            tick();
            n++;
            if (ack_m === 1'b1) seen = 1;
        end
        check({tag, ":latency"},   n,       128 * d);
        check({tag, ":csb_low"},   low,     128 * d);
        check({tag, ":sck_rise1"}, rise1,   d);
        check({tag, ":sck_rise2"}, rise2,   3 * d);
        check({tag, ":hdr"},       hdr_m,   exp_hdr);
        check({tag, ":rdt"},       rdt_m,   exp_rdt);
        check({tag, ":ack_pins"},  {29'd0, csb_m, sck_m, mosi_m}, 32'h4);
        if (!keep_cyc) set_cyc(1'b0);
    endtask

    initial begin
        int acks;
        int high;
        int lows;

        for (int i = 0; i < 512; i++) mem[i] = i[7:0] ^ 8'h5A;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        sel = 1'b0;
        rst = 1'b1;
        bus1.wb_cyc = 1'b0; bus1.wb_adr = '0;
        bus3.wb_cyc = 1'b0; bus3.wb_adr = '0;
        repeat (3) tick();

        // Reset values.
        check("rst:csb",  {31'd0, csb1},  32'd1);
        check("rst:sck",  {31'd0, sck1},  32'd0);
        check("rst:mosi", {31'd0, mosi1}, 32'd0);
        check("rst:ack",  {31'd0, bus1.wb_ack}, 32'd0);
        check("rst:rdt",  bus1.wb_rdt, 32'd0);
        rst = 1'b0;
        tick();

        // 1: aligned read of address 0.
        start(24'h000000);
        wait_ack("t1", 1, 32'h0300_0000, 32'h4433_2211, 0, -1);
        tick();
        check("t1:ack_one_cycle", {31'd0, bus1.wb_ack}, 32'd0);
        check("t1:rdt_held",      bus1.wb_rdt, 32'h4433_2211);
        repeat (3) tick();

        // 2: unaligned address; low bits forced to zero on the wire.
        start(24'h000106);
        wait_ack("t2", 1, 32'h0300_0104, 32'h5D5C_5F5E, 0, -1);
        repeat (3) tick();

        // 3: CLK_DIV=3 instance.
        sel = 1'b1;
        start(24'h000000);
        wait_ack("t3", 3, 32'h0300_0000, 32'h4433_2211, 0, -1);
        repeat (3) tick();
        sel = 1'b0;

        // 4: back-to-back with cyc held through ack.
        start(24'h000104);
        wait_ack("t4a", 1, 32'h0300_0104, 32'h5D5C_5F5E, 1, -1);
        set_adr(24'h000010);
        high = 1;
        for (int i = 0; i < 10 && csb1 === 1'b1; i++) begin
            tick();
            if (csb1 === 1'b1) high++;
        end
        check("t4:deselect_cycles", high, 3);
        wait_ack("t4b", 1, 32'h0300_0010, 32'h4948_4B4A, 0, -1);
        repeat (3) tick();

        // 5: reset at bit 40.
        start(24'h000000);
        repeat (81) tick();
        rst = 1'b1;
        set_cyc(1'b0);
        tick();
        check("t5:csb",  {31'd0, csb1},  32'd1);
        check("t5:sck",  {31'd0, sck1},  32'd0);
        check("t5:mosi", {31'd0, mosi1}, 32'd0);
        check("t5:ack",  {31'd0, bus1.wb_ack}, 32'd0);
        check("t5:rdt",  bus1.wb_rdt, 32'd0);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus1.wb_ack === 1'b1) acks++;
        end
        check("t5:no_ack", acks, 0);
        start(24'h000008);
        wait_ack("t5b", 1, 32'h0300_0008, 32'h5150_5352, 0, -1);
        repeat (3) tick();

        // 6: cyc dropped at bit 10; transfer still completes, then bridge stays idle.
        start(24'h000010);
        wait_ack("t6", 1, 32'h0300_0010, 32'h4948_4B4A, 0, 21);
        acks = 0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus1.wb_ack === 1'b1) acks++;
            if (csb1 !== 1'b1) lows++;
        end
        check("t6:no_extra_ack", acks, 0);
        check("t6:stays_idle",   lows, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
